fb_channel_serializer: RTL

- Sits directly downstream of the 16-channel nonuniform filter bank (total_filter).
- Captures one frame of 16 wide channel outputs (39-bit, 32 fractional bits) on a frame strobe.
- Requantizes each channel to 16 bits with rounding and saturation.
- Streams the channels out one per beat, channel 0 first, over a valid/ready handshake to the downstream consumer, and counts frames dropped while a previous frame is still draining.

---
 rtl/fb_channel_serializer_if.sv | 30 +++
 rtl/fb_channel_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fb_channel_serializer_if.sv
// Frame-in / beat-out bundle between the filter bank, the channel serializer and its consumer.
// The master modport is the serializer side; slave is the surrounding environment.
interface fb_channel_serializer_if #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 39,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 8,
    parameter int CH_W   = 4
);
    logic                     frame_valid;
    logic [NUM_CH*IN_W-1:0]   filter_bank_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [CH_W-1:0]          out_chan;
    logic                     out_last;
    logic                     out_sat;
    logic                     busy;
    logic [CNT_W-1:0]         overrun_count;

    modport master (
        input  frame_valid, filter_bank_in, out_ready,
        output out_valid, out_data, out_chan, out_last, out_sat, busy, overrun_count
    );

    modport slave (
        output frame_valid, filter_bank_in, out_ready,
        input  out_valid, out_data, out_chan, out_last, out_sat, busy, overrun_count
    );
endinterface

// File: rtl/fb_channel_serializer.sv
// Snapshots one frame of wide filter-bank channels, requantizes each to OUT_W bits with
// round-half-up and saturation, and streams them out channel 0 first over valid/ready.
module fb_channel_serializer #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 39,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 18,
    parameter int CNT_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    fb_channel_serializer_if.master  bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0]  IDX_ZERO = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  IDX_ONE  = {{(CH_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic signed [IN_W:0] ROUND_C = {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [IN_W:0] SAT_HI  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_LO  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    // Returns {saturated, sample}: round half up, arithmetic shift, clamp to OUT_W signed.
    function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] shr;
        sum = $signed({x[IN_W-1], x}) + ROUND_C;
        shr = sum >>> SHIFT;
        if (shr > SAT_HI) begin
            requant = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if (shr < SAT_LO) begin
            requant = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            requant = {1'b0, shr[OUT_W-1:0]};
        end
    endfunction

    state_t              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q;
    logic                out_sat_q;
    logic                out_last_q;
    logic [CNT_W-1:0]    overrun_q;
    logic [IN_W-1:0]     snap_q [NUM_CH];
    logic                accept_s;
    logic                load_snap_s;
    logic                load_out_s;
    logic                ovr_inc_s;
    logic [OUT_W:0]      rq_s;

    assign accept_s = out_valid_q && bus.out_ready;
    // idx_d is the channel the output register will hold after this edge.
    assign rq_s     = requant(snap_q[idx_d]);

    // Next-state, channel index and load strobes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        load_snap_s = 1'b0;
        load_out_s  = 1'b0;
        ovr_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_valid) begin
                    load_snap_s = 1'b1;
                    idx_d       = IDX_ZERO;
                    state_d     = DRAIN;
                end else begin
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (accept_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    idx_d       = IDX_ZERO;
                    if (bus.frame_valid) begin
                        load_snap_s = 1'b1;
                        state_d     = DRAIN;
                    end else begin
                        state_d     = IDLE;
                    end
                end else begin
                    ovr_inc_s = bus.frame_valid;
                    if (!out_valid_q) begin
                        load_out_s  = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (accept_s) begin
                        idx_d      = idx_q + IDX_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        load_out_s = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                idx_d       = IDX_ZERO;
            end
        endcase
    end

    // Control state, output beat register and overrun counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= IDX_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            if (load_out_s) begin
                out_data_q <= rq_s[OUT_W-1:0];
                out_sat_q  <= rq_s[OUT_W];
                out_last_q <= (idx_d == IDX_LAST);
            end
            if (ovr_inc_s && (overrun_q != CNT_MAX)) begin
                overrun_q <= overrun_q + CNT_ONE;
            end
        end
    end

    // Frame snapshot bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= {IN_W{1'b0}};
            end
        end else if (load_snap_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= bus.filter_bank_in[IN_W*k +: IN_W];
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_chan      = idx_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_sat       = out_sat_q;
    assign bus.busy          = (state_q == DRAIN);
    assign bus.overrun_count = overrun_q;
endmodule
